// File: rtl/mult_pkg.sv
// Shared constants and FSM state type for the iterative 32x32 multiplier.
package mult_pkg;
  localparam int WIDTH  = 32;
  localparam int CNT_W  = 5;
  localparam int PROD_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/sll_stage.sv
// Combinational logical left shift of a zero-extended operand; feeds the
// accumulator adder with the current partial product.
module sll_stage #(
  parameter int PW   = 64,
  parameter int SH_W = 5
) (
  input  logic [PW-1:0]   din,
  input  logic [SH_W-1:0] sh,
  output logic [PW-1:0]   dout
);
  assign dout = din << sh;
endmodule

// File: rtl/seq_mult32.sv
// Iterative unsigned multiplier: one multiplier bit per cycle, shift-and-add.
// Optional SEQ_MULT_EARLY_EXIT_EN ends RUN once no higher multiplier bits remain.
module seq_mult32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  import mult_pkg::*;

  localparam int PW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [PW-1:0]    a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    prod_q, prod_d;
  // One extra counter bit so the closing RUN edge (count == WIDTH) is distinct
  // from the edge that processes the top multiplier bit.
  logic [CNT_W:0]   cnt_q, cnt_d;
  logic [PW-1:0]    pp;
  logic             last;

  sll_stage #(.PW(PW), .SH_W(CNT_W)) u_sll (
    .din  (a_q),
    .sh   (cnt_q[CNT_W-1:0]),
    .dout (pp)
  );

`ifdef SEQ_MULT_EARLY_EXIT_EN
  // Stop as soon as every remaining multiplier bit is zero; count 0 is never
  // terminal so the shortest run still spans one processing edge.
  assign last = (cnt_q != '0) && ((b_q >> cnt_q) == '0);
`else
  assign last = (cnt_q == (CNT_W+1)'(WIDTH));
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          a_d     = PW'(a);
          b_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (last) begin
          state_d = DONE;
          prod_d  = acc_q;
        end else begin
          if (b_q[cnt_q[CNT_W-1:0]]) acc_d = acc_q + pp;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = prod_q;
endmodule

// File: tb/tb_seq_mult32.sv
// Self-checking bench for seq_mult32: randomized and directed operations
// compared against plain 64-bit multiplication and the expected latency.
module tb_seq_mult32;
  logic        clock;
  logic        reset_n;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] product;

  int n_total  = 0;
  int n_passed = 0;

  seq_mult32 dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y);
    longint unsigned p;
    p = longint'(x) * longint'(y);
    return p;
  endfunction

  function automatic int ref_lat(input logic [31:0] y);
`ifdef SEQ_MULT_EARLY_EXIT_EN
    int h;
    h = 0;
    for (int k = 0; k < 32; k++) if (y[k]) h = k;
    return 2 + h;
`else
    return 33 + 0 * int'(y[0]);
`endif
  endfunction

  // Launch one operation from IDLE or DONE and wait for its done pulse.
  // Returns at #1 after the edge that raised done.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_, input string nm);
    logic [63:0] prev;
    int lat, disturb;
    prev  = product;
    start = 1'b1; a = ta; b = tb_;
    @(posedge clock); #1;
    start = 1'b0;
    n_total++;
    if (busy !== 1'b1) $display("FAIL %s busy_after_accept: got %b want 1", nm, busy);
    else n_passed++;
    lat = 0; disturb = 0;
    while (done !== 1'b1 && lat < 100) begin
      a = $urandom; b = $urandom;
      if (product !== prev) disturb++;
      @(posedge clock); #1;
      lat++;
    end
    n_total++;
    if (lat !== ref_lat(tb_)) $display("FAIL %s latency: got %0d want %0d", nm, lat, ref_lat(tb_));
    else n_passed++;
    n_total++;
    if (product !== ref_prod(ta, tb_))
      $display("FAIL %s product: got %h want %h", nm, product, ref_prod(ta, tb_));
    else n_passed++;
    n_total++;
    if (disturb !== 0) $display("FAIL %s product_held_in_run: got %0d changes want 0", nm, disturb);
    else n_passed++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      n_total++;
      if ({busy, done, product} !== 66'd0)
        $display("FAIL reset_idle c%0d: got busy=%b done=%b product=%h want 0/0/0", c, busy, done, product);
      else n_passed++;
    end
  endtask

  task automatic test_basic();
    do_op(32'd3, 32'd5, "basic");
    @(posedge clock); #1;
    n_total++;
    if (done !== 1'b0 || product !== 64'd15)
      $display("FAIL basic_pulse_hold: got done=%b product=%h want 0/15", done, product);
    else n_passed++;
  endtask

  task automatic test_max();
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max");
    n_total++;
    if (product !== 64'hFFFF_FFFE_0000_0001)
      $display("FAIL max_const: got %h want fffffffe00000001", product);
    else n_passed++;
    @(posedge clock); #1;
  endtask

  task automatic test_ignored_start();
    int ndone;
    start = 1'b1; a = 32'd7; b = 32'd9;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1 start = 1'b1; a = 32'd1; b = 32'd1;
    @(posedge clock); #1;
    start = 1'b0; a = '0; b = '0;
    ndone = 0;
    for (int c = 0; c < 60; c++) begin
      if (done === 1'b1) ndone++;
      @(posedge clock); #1;
    end
    n_total++;
    if (ndone !== 1) $display("FAIL ignored_start_done_count: got %0d want 1", ndone);
    else n_passed++;
    n_total++;
    if (product !== 64'd63) $display("FAIL ignored_start_product: got %h want 63", product);
    else n_passed++;
  endtask

  task automatic test_back_to_back();
    do_op(32'd12345, 32'd678, "b2b_first");
    do_op(32'h1_0000, 32'h1_0000, "b2b_second");
    n_total++;
    if (product !== 64'h1_0000_0000) $display("FAIL b2b_const: got %h want 100000000", product);
    else n_passed++;
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid_run();
    int ndone;
    start = 1'b1; a = 32'd5; b = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (12) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    n_total++;
    if ({busy, done, product} !== 66'd0)
      $display("FAIL reset_mid_run_async: got busy=%b done=%b product=%h want 0/0/0", busy, done, product);
    else n_passed++;
    @(posedge clock); #1 reset_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1 || busy === 1'b1) ndone++;
      @(posedge clock); #1;
    end
    n_total++;
    if (ndone !== 0) $display("FAIL reset_mid_run_no_done: got %0d active cycles want 0", ndone);
    else n_passed++;
    do_op(32'd2, 32'h8000_0000, "after_reset");
    @(posedge clock); #1;
  endtask

  task automatic test_zero_operands();
    do_op(32'hDEAD_BEEF, 32'd0, "b_zero");
    @(posedge clock); #1;
    do_op(32'd0, 32'hCAFE_F00D, "a_zero");
    @(posedge clock); #1;
    do_op(32'd9, 32'd2, "small_b");
    @(posedge clock); #1;
  endtask

  task automatic test_random();
    logic [31:0] ra, rb;
    for (int n = 0; n < 10; n++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      do_op(ra, rb, "random");
      if (n[0]) begin
        @(posedge clock); #1;
      end
    end
    @(posedge clock); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_run();
    test_zero_operands();
    test_random();
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end
endmodule
